// File: rtl/ip_hdr_tx.sv
`default_nettype none
// ip_hdr_tx: owns the 20-byte IP header buffer and streams header + payload frames.
// Define IP_HDR_TX_PAD_EN to zero-pad payloads shorter than PAD_MIN bytes.
module ip_hdr_tx #(
   parameter int MAX_PAYLOAD = 1480,
   parameter int PAD_MIN     = 26
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [4:0]  i_iph_idx,
   input  logic [7:0]  i_iph_byte,
   input  logic        i_wr_iph_en,
   input  logic        i_iph_ready,
   input  logic [15:0] i_data_length,
   input  logic [7:0]  i_pl_data,
   input  logic        i_pl_valid,
   output logic        o_pl_ready,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_tx_sof,
   output logic        o_tx_eof,
   output logic        o_busy,
   output logic        o_err
);

   localparam int HDR_BYTES = 20;
`ifdef IP_HDR_TX_PAD_EN
   localparam logic PAD_EN = 1'b1;
`else
   localparam logic PAD_EN = 1'b0;
`endif

   localparam logic [7:0] HDR_RST [HDR_BYTES] = '{
      8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
      8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF
   };

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_PAY  = 3'd2,
      ST_DONE = 3'd3
`ifdef IP_HDR_TX_PAD_EN
      , ST_PAD = 3'd4
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  hdr_q [HDR_BYTES];
   logic [4:0]  hcnt_q, hcnt_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic [15:0] len_q, len_d;
   logic        rdy_s1_q, rdy_s2_q;
   logic        err_q;

   logic start, len_bad, hdr_wr, hdr_drop, hdr_last, pay_last, need_pad;

   // Edge taken between two register stages: one cycle to sample, one to enter HDR.
   assign start    = rdy_s1_q & ~rdy_s2_q & (state_q == ST_IDLE);
   assign len_bad  = i_data_length > 16'(MAX_PAYLOAD);
   assign hdr_wr   = i_wr_iph_en & (state_q == ST_IDLE) & (i_iph_idx < 5'(HDR_BYTES));
   assign hdr_drop = i_wr_iph_en & (state_q != ST_IDLE);
   assign hdr_last = hcnt_q == 5'(HDR_BYTES - 1);
   assign pay_last = pcnt_q == (len_q - 16'd1);
   assign need_pad = PAD_EN & (len_q < 16'(PAD_MIN));
   assign o_busy   = state_q != ST_IDLE;
   assign o_err    = err_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < HDR_BYTES; i++) begin
            hdr_q[i] <= HDR_RST[i];
         end
      end else if (hdr_wr) begin
         hdr_q[i_iph_idx] <= i_iph_byte;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         hcnt_q   <= '0;
         pcnt_q   <= '0;
         len_q    <= '0;
         rdy_s1_q <= 1'b0;
         rdy_s2_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hcnt_q   <= hcnt_d;
         pcnt_q   <= pcnt_d;
         len_q    <= len_d;
         rdy_s1_q <= i_iph_ready;
         rdy_s2_q <= rdy_s1_q;
         if (hdr_drop || (start && len_bad)) begin
            err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      hcnt_d     = hcnt_q;
      pcnt_d     = pcnt_q;
      len_d      = len_q;
      o_tx_valid = 1'b0;
      o_tx_data  = 8'h00;
      o_tx_sof   = 1'b0;
      o_tx_eof   = 1'b0;
      o_pl_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d = i_data_length;
               if (!len_bad) begin
                  hcnt_d  = '0;
                  state_d = ST_HDR;
               end
            end
         end
         ST_HDR: begin
            o_tx_valid = 1'b1;
            o_tx_data  = hdr_q[hcnt_q];
            o_tx_sof   = hcnt_q == 5'd0;
            o_tx_eof   = hdr_last & (len_q == 16'd0) & ~need_pad;
            if (i_tx_ready) begin
               if (hdr_last) begin
                  pcnt_d = '0;
                  if (len_q != 16'd0) begin
                     state_d = ST_PAY;
                  end else begin
`ifdef IP_HDR_TX_PAD_EN
                     state_d = need_pad ? ST_PAD : ST_DONE;
`else
                     state_d = ST_DONE;
`endif
                  end
               end else begin
                  hcnt_d = hcnt_q + 5'd1;
               end
            end
         end
         ST_PAY: begin
            o_tx_valid = i_pl_valid;
            o_tx_data  = i_pl_data;
            o_pl_ready = i_tx_ready;
            o_tx_eof   = pay_last & ~need_pad;
            if (i_pl_valid && i_tx_ready) begin
               pcnt_d = pcnt_q + 16'd1;
               if (pay_last) begin
`ifdef IP_HDR_TX_PAD_EN
                  state_d = need_pad ? ST_PAD : ST_DONE;
`else
                  state_d = ST_DONE;
`endif
               end
            end
         end
`ifdef IP_HDR_TX_PAD_EN
         // pcnt keeps counting from len so the frame ends at PAD_MIN payload bytes.
         ST_PAD: begin
            o_tx_valid = 1'b1;
            o_tx_eof   = pcnt_q == 16'(PAD_MIN - 1);
            if (i_tx_ready) begin
               pcnt_d = pcnt_q + 16'd1;
               if (pcnt_q == 16'(PAD_MIN - 1)) begin
                  state_d = ST_DONE;
               end
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
